// File: rtl/alu_wb_pkg.sv
// Shared types and constants for the ALU result writeback block.
// ALU_WB_SATURATE_EN selects one clamped word per lane instead of lo/hi pairs.
package alu_wb_pkg;

    localparam int unsigned LANES_DEF  = 16;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } wb_state_t;

    function automatic int unsigned words_per_vector(input int unsigned lanes);
`ifdef ALU_WB_SATURATE_EN
        return lanes;
`else
        return 2 * lanes;
`endif
    endfunction

    localparam int unsigned NUM_WORDS = words_per_vector(LANES_DEF);

endpackage

// File: rtl/alu_result_writeback_if.sv
// Result-vector capture and memory write bus of the ALU writeback stage.
// slave = writeback block view, master = ALU/memory environment view.
interface alu_result_writeback_if
    import alu_wb_pkg::*;
#(
    parameter int unsigned LANES  = LANES_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);

    logic                           res_valid;
    logic                           res_ready;
    logic [LANES-1:0][DATA_W-1:0]   res_lo;
    logic [LANES-1:0][DATA_W-1:0]   res_hi;
    logic [ADDR_W-1:0]              base_addr;
    logic                           mem_we;
    logic [ADDR_W-1:0]              mem_addr;
    logic [DATA_W-1:0]              mem_wdata;
    logic                           mem_ready;

    modport slave (
        input  res_valid, res_lo, res_hi, base_addr, mem_ready,
        output res_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output res_valid, res_lo, res_hi, base_addr, mem_ready,
        input  res_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/alu_wb_sat_clamp.sv
// Combinational clamp of a signed 2*DATA_W value to the signed DATA_W range.
// Instantiated per lane only when ALU_WB_SATURATE_EN is defined.
module alu_wb_sat_clamp #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2*DATA_W-1:0] wide,
    output logic [DATA_W-1:0]   sat
);

    logic in_range;

    // In range iff the upper DATA_W+1 bits are pure sign extension.
    assign in_range = (wide[2*DATA_W-1:DATA_W-1] == '0) ||
                      (wide[2*DATA_W-1:DATA_W-1] == '1);

    always_comb begin
        sat = wide[DATA_W-1:0];
        if (!in_range) begin
            if (wide[2*DATA_W-1]) begin
                sat = {1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                sat = {1'b0, {(DATA_W-1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/alu_result_writeback.sv
// Captures one ALU result vector and serialises it into 32-bit memory writes.
// ALU_WB_SATURATE_EN: write one clamped word per lane at base+lane.
module alu_result_writeback
    import alu_wb_pkg::*;
#(
    parameter int unsigned LANES  = LANES_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    alu_result_writeback_if.slave   bus,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned WORDS = words_per_vector(LANES);
    localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    wb_state_t                      state_q, state_d;
    logic [CNT_W-1:0]               k_q;
    logic [WORDS-1:0][DATA_W-1:0]   word_buf_q;
    logic [WORDS-1:0][DATA_W-1:0]   cap_words;
    logic [ADDR_W-1:0]              addr_q;
    logic                           we_q;
    logic                           capture;
    logic                           accept;
    logic                           last_word;

    // Word layout is fixed at capture so the write phase is a plain index.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
`ifdef ALU_WB_SATURATE_EN
        alu_wb_sat_clamp #(.DATA_W(DATA_W)) u_clamp (
            .wide ({bus.res_hi[i], bus.res_lo[i]}),
            .sat  (cap_words[i])
        );
`else
        assign cap_words[2*i]   = bus.res_lo[i];
        assign cap_words[2*i+1] = bus.res_hi[i];
`endif
    end

    assign capture   = (state_q == IDLE) && bus.res_valid;
    assign accept    = (state_q == WRITE) && we_q && bus.mem_ready;
    assign last_word = (k_q == CNT_W'(WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.res_ready = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state_q)
            IDLE: begin
                bus.res_ready = 1'b1;
                if (bus.res_valid) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                busy = 1'b1;
                if (accept && last_word) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_buf_q <= '0;
            addr_q     <= '0;
            k_q        <= '0;
            we_q       <= 1'b0;
        end else if (capture) begin
            word_buf_q <= cap_words;
            addr_q     <= bus.base_addr;
            k_q        <= '0;
            we_q       <= 1'b1;
        end else if (accept) begin
            if (last_word) begin
                addr_q <= '0;
                k_q    <= '0;
                we_q   <= 1'b0;
            end else begin
                addr_q <= addr_q + 1'b1;
                k_q    <= k_q + 1'b1;
            end
        end
    end

    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = we_q ? word_buf_q[k_q] : '0;

endmodule
